alu_cdb_unit: RTL
=================

Name: alu_cdb_unit

Overview:
- Execution stage directly downstream of the reservation station in the Tomasulo core.
- Accepts one ready-to-execute op per cycle (opcode, two 32-bit operands, ROB tag) and computes it.
- Queues results in a small FIFO and broadcasts the head on the common data bus (CDB) to the ROB under a valid/ack handshake.
- Gives back-pressure to the reservation station; flushed by branch-mispredict clear.

Parameters:
- DEPTH, 4, result FIFO entries (power of 2, >=2).
- ROB_W, 5, ROB tag width.
- OP_W, 6, opcode width.

Ports:
- clk_in  in  1  clock, all state on rising edge.
- rst_in_n  in  1  asynchronous active-low reset.
- rdy_in  in  1  global enable; when low, all state holds and no push/pop occurs.
- clear  in  1  synchronous flush (mispredict).
- calc_en  in  1  RS issues an op this cycle.
- opcode_in  in  OP_W  operation select.
- val1  in  32  operand 1.
- val2  in  32  operand 2 (immediate already substituted).
- rob_tag_in  in  ROB_W  destination ROB entry.
- alu_stall  out  1  RS must not assert calc_en next cycle.
- cdb_valid  out  1  FIFO head is valid.
- cdb_tag  out  ROB_W  head ROB tag.
- cdb_val  out  32  head result.
- cdb_ack  in  1  consumer takes the head this cycle.
- overflow  out  1  sticky: calc_en arrived while FIFO full.

Behaviour:
- Reset (rst_in_n=0, immediate, asynchronous): FIFO empty, pointers 0, count 0; cdb_valid=0, cdb_tag=0, cdb_val=0, alu_stall=0, overflow=0.
- Opcodes (others yield result 0 but are still pushed):
  - 0 ADD
  - 1 SUB
  - 2 SLL (shamt=val2[4:0])
  - 3 SLT (signed)
  - 4 SLTU
  - 5 XOR
  - 6 SRL
  - 7 SRA
  - 8 OR
  - 9 AND
  - 10 BEQ
  - 11 BNE
  - 12 BLT
  - 13 BGE
  - 14 BLTU
  - 15 BGEU (branch ops return 32'd1 if taken else 0)
  - 16 PASS (result=val2, for LUI/AUIPC)
  - All arithmetic is mod 2^32.
- Push: at a rising edge with rdy_in=1, clear=0, calc_en=1 and count<DEPTH, compute the result combinationally from the inputs and write {tag, result} at the tail.
- Pop: at the same kind of edge, with cdb_valid=1 and cdb_ack=1, advance the head. cdb_ack while cdb_valid=0 is ignored.
- Simultaneous push and pop: both occur and count is unchanged. Push and pop on a full FIFO: the pop frees a slot, so the push is accepted.
- Push while full with no pop: op dropped, overflow set until reset. overflow is not cleared by clear.
- Latency: calc_en sampled at edge N with FIFO empty gives cdb_valid=1 after edge N (1 cycle). Results leave in issue order.
- cdb_valid/cdb_tag/cdb_val are driven from the FIFO head (registered storage) and stay stable while cdb_valid=1 and cdb_ack=0.
- alu_stall: registered, equals (next count >= DEPTH-1), so RS always sees back-pressure one cycle early.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- clear=1 (with rdy_in=1): FIFO emptied, same-cycle calc_en and cdb_ack ignored, cdb_valid=0 and alu_stall=0 after the edge.
- rdy_in=0: no push, pop or clear action; outputs hold.
- Reset mid-operation: all queued results are discarded immediately.

Optional Feature:
- Macro: ALU_STATS_EN.
- Defined: adds outputs stat_issued (32), stat_broadcast (32) and stat_max_occ (log2(DEPTH)+1).
  - stat_issued counts accepted pushes; stat_broadcast counts pops; stat_max_occ is the high-water mark of count.
  - All three reset to 0 on rst_in_n only (not on clear). Counters wrap at 2^32.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then single op: calc_en, opcode 0, val1=5, val2=7, tag=3, cdb_ack=0 -> after 1 edge cdb_valid=1, cdb_tag=3, cdb_val=12, held until cdb_ack=1, then cdb_valid=0.
- Arithmetic corners:
  - SUB 0-1 -> 32'hFFFFFFFF
  - SRA 32'h80000000 by 31 -> 32'hFFFFFFFF
  - SLT -1<1 -> 1, SLTU -1<1 -> 0
  - BGEU 3,3 -> 1
  - PASS val2=32'h12345000 -> 32'h12345000
- Fill with DEPTH=4 and no ack: after 3 pushes alu_stall=1. 4th push accepted; 5th push dropped, overflow=1, head still first tag.
- Simultaneous push+pop on full FIFO: count stays 4, order preserved (tags 1,2,3,4 then 5 emerge in order).
- clear with 3 queued plus same-cycle calc_en -> cdb_valid=0, alu_stall=0 next cycle. Next push appears with 1-cycle latency.
- rdy_in=0 for 3 cycles with calc_en and cdb_ack high -> no state change. Asserting rst_in_n=0 mid-queue -> cdb_valid drops immediately without a clock edge.

Source files
------------

// File: rtl/alu_cdb_unit.sv
// alu_cdb_unit: Tomasulo execute stage, ALU plus CDB result FIFO.
// Optional ALU_STATS_EN adds issue/broadcast/occupancy counters.
module alu_cdb_unit #(
  parameter int DEPTH = 4,
  parameter int ROB_W = 5,
  parameter int OP_W  = 6
) (
  input  logic             clk_in,
  input  logic             rst_in_n,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             calc_en,
  input  logic [OP_W-1:0]  opcode_in,
  input  logic [31:0]      val1,
  input  logic [31:0]      val2,
  input  logic [ROB_W-1:0] rob_tag_in,
  output logic             alu_stall,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_tag,
  output logic [31:0]      cdb_val,
  input  logic             cdb_ack,
  output logic             overflow
`ifdef ALU_STATS_EN
  ,
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_broadcast,
  output logic [$clog2(DEPTH):0] stat_max_occ
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_BGE  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_BLTU = OP_W'(14);
  localparam logic [OP_W-1:0] OP_BGEU = OP_W'(15);
  localparam logic [OP_W-1:0] OP_PASS = OP_W'(16);

  logic [ROB_W-1:0] tag_q [DEPTH];
  logic [ROB_W-1:0] tag_d [DEPTH];
  logic [31:0]      val_q [DEPTH];
  logic [31:0]      val_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             stall_q, stall_d;
  logic             ovf_q, ovf_d;

  logic [31:0] res;
  logic [4:0]  shamt;
  logic        lt_s, lt_u, eq;
  logic        act, push, pop, full;

  assign shamt = val2[4:0];
  assign lt_s  = $signed(val1) < $signed(val2);
  assign lt_u  = val1 < val2;
  assign eq    = val1 == val2;

  // ALU: pure function of the issued operands
  always_comb begin
    res = '0;
    case (opcode_in)
      OP_ADD:  res = val1 + val2;
      OP_SUB:  res = val1 - val2;
      OP_SLL:  res = val1 << shamt;
      OP_SLT:  res = {31'd0, lt_s};
      OP_SLTU: res = {31'd0, lt_u};
      OP_XOR:  res = val1 ^ val2;
      OP_SRL:  res = val1 >> shamt;
      OP_SRA:  res = $unsigned($signed(val1) >>> shamt);
      OP_OR:   res = val1 | val2;
      OP_AND:  res = val1 & val2;
      OP_BEQ:  res = {31'd0, eq};
      OP_BNE:  res = {31'd0, ~eq};
      OP_BLT:  res = {31'd0, lt_s};
      OP_BGE:  res = {31'd0, ~lt_s};
      OP_BLTU: res = {31'd0, lt_u};
      OP_BGEU: res = {31'd0, ~lt_u};
      OP_PASS: res = val2;
      default: res = '0;
    endcase
  end

  assign act       = rdy_in & ~clear;
  assign full      = count_q == CW'(DEPTH);
  assign cdb_valid = count_q != '0;
  assign pop       = act & cdb_valid & cdb_ack;
  assign push      = act & calc_en & (~full | pop);

  // FIFO next state: a pop on a full FIFO frees room for the push
  always_comb begin
    tag_d    = tag_q;
    val_d    = val_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      tag_d[wr_ptr_q] = rob_tag_in;
      val_d[wr_ptr_q] = res;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (act & calc_en & full & ~pop) ovf_d = 1'b1;
    if (rdy_in & clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    stall_d = count_d >= CW'(DEPTH - 1);
  end

  // State registers
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        val_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      tag_q    <= tag_d;
      val_q    <= val_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cdb_tag   = tag_q[rd_ptr_q];
  assign cdb_val   = val_q[rd_ptr_q];
  assign alu_stall = stall_q;
  assign overflow  = ovf_q;

`ifdef ALU_STATS_EN
  logic [31:0]   iss_q, iss_d;
  logic [31:0]   bc_q, bc_d;
  logic [CW-1:0] max_q, max_d;

  // Statistics next state; survives clear
  always_comb begin
    iss_d = iss_q + 32'(push);
    bc_d  = bc_q + 32'(pop);
    max_d = max_q;
    if (count_d > max_q) max_d = count_d;
  end

  // Statistics registers
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      iss_q <= '0;
      bc_q  <= '0;
      max_q <= '0;
    end else begin
      iss_q <= iss_d;
      bc_q  <= bc_d;
      max_q <= max_d;
    end
  end

  assign stat_issued    = iss_q;
  assign stat_broadcast = bc_q;
  assign stat_max_occ   = max_q;
`endif

endmodule
